// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter:
// FSM state encoding and the double-dabble digit-adjust constants.
package bin_to_bcd_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // A digit at or above the threshold would exceed 9 after doubling,
  // so it is pre-corrected by adding 3 before the shift.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake/data bundle between a client and the BCD converter.
// The master drives start/bin_in; the slave (converter) returns results.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     blank_out;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, blank_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, blank_out
  );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// One double-dabble digit correction: d >= 5 ? d + 3 : d.
module bcd_digit_adjust
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Result never wraps: the largest legal input 9 becomes 12.
  assign q = (d >= BCD_ADJ_THRESH) ? d + BCD_ADJ_ADD : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, with a
// start/busy/done handshake and a leading-zero blanking mask for the
// downstream 7-segment decoders. Results hold until the next conversion.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic            clk,
  input  logic            reset,
  bin_to_bcd_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]          state;
  logic [WIDTH-1:0]    shift;
  logic [WIDTH-1:0]    shift_next;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adjusted;
  logic [4*DIGITS-1:0] scratch_next;
  logic [CW-1:0]       count;
  logic [DIGITS-1:0]   mask_next;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   blank_q;

  // Per-digit +3 correction, applied to the pre-shift scratch digits.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d(scratch[4*i +: 4]),
      .q(adjusted[4*i +: 4])
    );
  end

  // The adjusted scratch and the binary shift register move left as one word.
  assign {scratch_next, shift_next} = {adjusted, shift} << 1;

  // Leading-zero mask of the post-shift scratch: bit i set while every digit
  // from i upward is zero; digit 0 is always shown.
  always_comb begin : blank_calc
    logic upper_zero;
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    upper_zero = 1'b1;
    mask_next  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero & (scratch_next[4*i +: 4] == 4'd0);
      mask_next[i] = upper_zero;
    end
  end

  // Conversion FSM. The result and mask are captured on the final shift
  // so they are already valid in the DONE cycle that carries the done pulse.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
    if (reset) begin
      state   <= ST_IDLE;
      shift   <= '0;
      scratch <= '0;
      count   <= '0;
      bcd_q   <= '0;
      blank_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            shift   <= bus.bin_in;
            scratch <= '0;
            count   <= CW'(WIDTH);
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch <= scratch_next;
          shift   <= shift_next;
          count   <= count - 1'b1;
          if (count == CW'(1)) begin
            state   <= ST_DONE;
            bcd_q   <= scratch_next;
            blank_q <= mask_next;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.bcd_out   = bcd_q;
  assign bus.blank_out = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a cycle-count/decimal-arithmetic
// model checked every cycle, plus directed vectors with literal results.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by plain division, least significant first.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit i is a leading zero exactly when the value is below 10**i.
  function automatic logic [DIGITS-1:0] blank_of(input int unsigned v);
    logic [DIGITS-1:0] b;
    int unsigned p;
    b = '0;
    p = 1;
    for (int i = 1; i < DIGITS; i++) begin
      p = p * 10;
      b[i] = (v < p);
    end
    return b;
  endfunction

  // Model: a conversion occupies WIDTH+1 busy cycles, done on the last one.
  int                  m_rem = 0;
  int unsigned         m_val = 0;
  logic [4*DIGITS-1:0] m_bcd = '0;
  logic [DIGITS-1:0]   m_blank = '0;
  bit                  cmp_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_rem   = 0;
      m_bcd   = '0;
      m_blank = '0;
    end else if (m_rem == 0) begin
      if (bus.start) begin
        m_val = bus.bin_in;
        m_rem = WIDTH + 1;
      end
    end else begin
      m_rem--;
      if (m_rem == 1) begin
        m_bcd   = to_bcd(m_val);
        m_blank = blank_of(m_val);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy",  bus.busy,      m_rem != 0);
      check("cyc_done",  bus.done,      m_rem == 1);
      check("cyc_bcd",   bus.bcd_out,   m_bcd);
      check("cyc_blank", bus.blank_out, m_blank);
    end
  end

  // One full conversion from IDLE; ends on the negedge after the done cycle.
  task automatic run(input logic [WIDTH-1:0] val, input logic [4*DIGITS-1:0] exp_bcd,
                     input logic [DIGITS-1:0] exp_blank, input string tag);
    int lat;
    lat = 0;
    bus.start  = 1'b1;
    bus.bin_in = val;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, WIDTH + 1);
    check({tag, "_bcd"},     bus.bcd_out,   exp_bcd);
    check({tag, "_blank"},   bus.blank_out, exp_blank);
    check({tag, "_model"},   m_bcd,         exp_bcd);
    @(negedge clk);
    check({tag, "_idle"},    bus.busy,      1'b0);
  endtask

  initial begin
    int lat;
    int dk [3];
    int nd;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;

    // Reset held three cycles, then idle.
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_busy",  bus.busy,      1'b0);
    check("rst_done",  bus.done,      1'b0);
    check("rst_bcd",   bus.bcd_out,   20'h00000);
    check("rst_blank", bus.blank_out, 5'b00000);

    run(16'd1234,  20'h01234, 5'b10000, "v1234");
    run(16'd65535, 20'h65535, 5'b00000, "v65535");
    run(16'd0,     20'h00000, 5'b11110, "v0");

    // Starts during SHIFT and during DONE are ignored.
    lat = 0;
    bus.start  = 1'b1;
    bus.bin_in = 16'd42;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 5) begin
        bus.start  = 1'b1;
        bus.bin_in = 16'd999;
      end
      if (k == 6) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("ign_latency", lat, WIDTH + 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_idle",  bus.busy,      1'b0);
    check("ign_bcd",   bus.bcd_out,   20'h00042);
    check("ign_blank", bus.blank_out, 5'b11100);
    run(16'd999, 20'h00999, 5'b11000, "v999");

    // Reset in the 8th SHIFT cycle aborts the conversion.
    bus.start  = 1'b1;
    bus.bin_in = 16'd500;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",  bus.busy,      1'b0);
    check("abort_done",  bus.done,      1'b0);
    check("abort_bcd",   bus.bcd_out,   20'h00000);
    check("abort_blank", bus.blank_out, 5'b00000);
    @(negedge clk);
    run(16'd7, 20'h00007, 5'b11110, "v7");

    // Continuous start: one conversion every WIDTH+2 cycles.
    nd = 0;
    bus.start  = 1'b1;
    bus.bin_in = 16'd10;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dk[nd] = k;
        nd++;
        check("b2b_bcd",   bus.bcd_out,   20'h00010);
        check("b2b_blank", bus.blank_out, 5'b11100);
        if (nd == 3) break;
      end
    end
    bus.start = 1'b0;
    check("b2b_count", nd, 3);
    if (nd == 3) begin
      check("b2b_first", dk[0], WIDTH + 1);
      check("b2b_gap1",  dk[1] - dk[0], WIDTH + 2);
      check("b2b_gap2",  dk[2] - dk[1], WIDTH + 2);
    end
    @(negedge clk);
    @(negedge clk);
    check("b2b_stop", bus.busy, 1'b0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
